// File: rtl/rx_img_loader_if.sv
// Bundle of the rx_img_loader handshake and RAM-write signals.
//   master : the loader side (takes the UART byte and ack, drives RAM writes and status)
//   slave  : the environment side (UART receiver, pixel RAM, image consumer)
// Signals:
//   rx_rdy   - one-cycle pulse, rx_data valid
//   rx_data  - received byte, bit 0 is the earliest pixel
//   img_ack  - consumer finished with the stored image
//   ram_we   - pixel RAM write strobe
//   ram_addr - pixel RAM write address
//   ram_din  - pixel value written
//   img_done - level high while a complete image is held
//   overrun  - sticky flag for a dropped byte
interface rx_img_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              img_ack;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_din;
  logic              img_done;
  logic              overrun;

  modport master (
    input  rx_rdy, rx_data, img_ack,
    output ram_we, ram_addr, ram_din, img_done, overrun
  );

  modport slave (
    output rx_rdy, rx_data, img_ack,
    input  ram_we, ram_addr, ram_din, img_done, overrun
  );
endinterface

// File: rtl/rx_img_loader.sv
// Unpacks UART bytes into a 1-bit-per-pixel image RAM, LSB first, one pixel
// per clock. Holds the image (img_done) until the consumer acks it.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - rx_img_loader_if master modport (byte in, ack in, RAM write and status out)
//
// state  | meaning
// IDLE   | waiting for a byte from the UART
// UNPACK | writing the 8 bits of the captured byte, one per cycle
// FULL   | complete image held, waiting for img_ack
module rx_img_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10
) (
  input logic              clk,
  input logic              rst_n,
  rx_img_loader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              overrun_q, overrun_d;
  logic              ram_we_q, ram_we_d;
  logic              img_done_q, img_done_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_rdy) begin
          shift_d   = bus.rx_data;
          bit_cnt_d = 3'd0;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          // Counter parks on the last address instead of wrapping.
          if (pix_cnt_q == LAST_PIX) begin
            state_d = FULL;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = IDLE;
          end
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (bus.rx_rdy) overrun_d = 1'b1;
      end
      FULL: begin
        if (bus.img_ack) begin
          pix_cnt_d = '0;
          overrun_d = 1'b0;
          state_d   = IDLE;
        end
        // A byte arriving with the ack is still a drop: set wins over clear.
        if (bus.rx_rdy) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ram_we_d   = (state_d == UNPACK);
    img_done_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      pix_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      img_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      overrun_q  <= overrun_d;
      ram_we_q   <= ram_we_d;
      img_done_q <= img_done_d;
    end
  end

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = pix_cnt_q;
  assign bus.ram_din  = shift_q[0];
  assign bus.img_done = img_done_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_rx_img_loader.sv
// Directed bench for rx_img_loader: single byte unpack, full image load,
// overrun during UNPACK and FULL, ack handling, async reset.
module tb_rx_img_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  rx_img_loader_if #(.ADDR_W(10)) bus ();

  rx_img_loader #(.NUM_PIXELS(784), .ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [9:0] addr,
                                  input logic done, input logic ovr);
    chk({tag, ".we"},   32'(bus.ram_we),   32'd0);
    chk({tag, ".addr"}, 32'(bus.ram_addr), 32'(addr));
    chk({tag, ".done"}, 32'(bus.img_done), 32'(done));
    chk({tag, ".ovr"},  32'(bus.overrun),  32'(ovr));
  endtask

  // Pulse rx_rdy for one cycle, then check the 8 writes that follow. Returns
  // at the negedge after the last write.
  task automatic send_check(input logic [7:0] b, input logic [9:0] base);
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("wr.we",   32'(bus.ram_we),   32'd1);
      chk("wr.addr", 32'(bus.ram_addr), 32'(base + 10'(i)));
      chk("wr.din",  32'(bus.ram_din),  32'(b[i]));
      @(negedge clk);
    end
    chk("post.we", 32'(bus.ram_we), 32'd0);
  endtask

  task automatic fill_image();
    for (int k = 0; k < 98; k++) begin
      send_check(8'hFF, 10'(k * 8));
      if (k < 97) chk("fill.done_lo", 32'(bus.img_done), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b3c;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    bus.img_ack = 1'b0;
    rst_n       = 1'b0;
    b3c         = 8'h3C;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset", 10'd0, 1'b0, 1'b0);
    chk("reset.din", 32'(bus.ram_din), 32'd0);
    rst_n = 1'b1;

    // Single byte 0xA5 -> din 1,0,1,0,0,1,0,1 at addr 0..7
    send_check(8'hA5, 10'd0);
    chk_idle_outputs("a5.after", 10'd8, 1'b0, 1'b0);

    // img_ack outside FULL is ignored
    @(negedge clk);
    bus.img_ack = 1'b1;
    @(negedge clk);
    bus.img_ack = 1'b0;
    chk_idle_outputs("ack_idle", 10'd8, 1'b0, 1'b0);

    // Second rx_rdy 3 cycles into UNPACK is dropped
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b3c;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'hFF;
      end
      if (i == 3) bus.rx_rdy = 1'b0;
      chk("ovr.we",   32'(bus.ram_we),   32'd1);
      chk("ovr.addr", 32'(bus.ram_addr), 32'(10'd8 + 10'(i)));
      chk("ovr.din",  32'(bus.ram_din),  32'(b3c[i]));
      @(negedge clk);
    end
    chk_idle_outputs("ovr.after", 10'd16, 1'b0, 1'b1);
    send_check(8'h81, 10'd16);
    chk_idle_outputs("ovr.sticky", 10'd24, 1'b0, 1'b1);

    // Async reset mid-UNPACK: outputs clear without a clock edge
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hFF;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    @(negedge clk);
    chk("pre_rst.we", 32'(bus.ram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst", 10'd0, 1'b0, 1'b0);
    chk("async_rst.din", 32'(bus.ram_din), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_check(8'h5A, 10'd0);

    // Full image of 0xFF bytes
    do_reset();
    fill_image();
    chk_idle_outputs("full", 10'd783, 1'b1, 1'b0);

    // Byte while FULL is dropped, then ack clears
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h77;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    chk_idle_outputs("full_drop", 10'd783, 1'b1, 1'b1);
    @(negedge clk);
    chk_idle_outputs("full_drop2", 10'd783, 1'b1, 1'b1);
    bus.img_ack = 1'b1;
    @(negedge clk);
    bus.img_ack = 1'b0;
    chk_idle_outputs("ack", 10'd0, 1'b0, 1'b0);
    send_check(8'h0F, 10'd0);

    // rx_rdy and img_ack in the same FULL cycle
    do_reset();
    fill_image();
    chk_idle_outputs("full2", 10'd783, 1'b1, 1'b0);
    @(negedge clk);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h55;
    bus.img_ack = 1'b1;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
    bus.img_ack = 1'b0;
    chk_idle_outputs("both", 10'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_idle_outputs("both2", 10'd0, 1'b0, 1'b1);
    send_check(8'hC3, 10'd0);
    chk_idle_outputs("both.after", 10'd8, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_img_loader.md
RX_IMG_LOADER -- requirements
Module: rx_img_loader

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 784, giving pixels per image (28x28 binary image).
REQ-002 SHALL have parameter ADDR_W, default 10, giving the pixel RAM address width; NUM_PIXELS <= 2**ADDR_W and NUM_PIXELS divisible by 8.
REQ-003 SHALL have port clk, input, 1, the single system clock (50 MHz); all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port rx_rdy, input, 1, one-cycle pulse from the UART receiver marking rx_data valid.
REQ-006 SHALL have port rx_data, input, 8, received byte; bit 0 is the earliest pixel.
REQ-007 SHALL have port img_ack, input, 1, downstream consumer has finished with the stored image.
REQ-008 SHALL have port ram_we, output, 1, pixel RAM write strobe.
REQ-009 SHALL have port ram_addr, output, ADDR_W, pixel RAM write address.
REQ-010 SHALL have port ram_din, output, 1, pixel value written.
REQ-011 SHALL have port img_done, output, 1, level high while a complete image is held.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a dropped byte.

Function
REQ-013 SHALL implement FSM states IDLE, UNPACK, FULL.
REQ-014 IDLE: on rx_rdy=1, capture rx_data into an 8-bit shift register, clear bit counter, go to UNPACK next cycle.
REQ-015 UNPACK: each cycle ram_we=1, ram_din=shift[0], ram_addr=pixel counter; then shift right one bit, increment bit counter and pixel counter.
REQ-016 UNPACK lasts exactly 8 cycles per byte; first write occurs the cycle after the rx_rdy pulse.
REQ-017 After the 8th write: if the pixel just written is address NUM_PIXELS-1, go to FULL; else return to IDLE.
REQ-018 ram_we SHALL be 0 in every state other than UNPACK; ram_addr SHALL equal the pixel counter in all states.
REQ-019 FULL: img_done=1, no RAM writes; on img_ack=1, clear the pixel counter to 0, clear overrun, go to IDLE next cycle.
REQ-020 img_ack SHALL be ignored outside FULL.
REQ-021 rx_rdy in UNPACK or FULL SHALL drop the byte, leave the shift register and counters unchanged, and set overrun=1.
REQ-022 If rx_rdy and img_ack are both 1 in FULL, the ack is processed, the byte is dropped, and overrun ends at 1 (set beats clear).
REQ-023 The pixel counter SHALL never exceed NUM_PIXELS-1 and SHALL NOT wrap within an image.
REQ-024 img_done SHALL be registered: high from the cycle after the last write until the cycle after img_ack.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, pixel counter=0, bit counter=0, shift register=0x00, ram_we=0, ram_addr=0, ram_din=0, img_done=0, overrun=0.
REQ-026 Reset mid-UNPACK or in FULL SHALL discard the partial or complete image; loading restarts at address 0 after release.

Verification
REQ-027 Single byte 0xA5 via rx_rdy pulse -> cycles 1..8 after pulse: ram_we=1, addr 0..7, din 1,0,1,0,0,1,0,1; then IDLE, ram_we=0.
REQ-028 98 bytes of 0xFF spaced 26050 cycles apart -> 784 writes at addr 0..783 all din=1; img_done=1 the cycle after addr 783; overrun=0.
REQ-029 Byte sent while FULL, then img_ack -> no write, overrun=1; after ack: img_done=0, overrun=0, next byte writes addr 0.
REQ-030 Second rx_rdy 3 cycles after the first (during UNPACK) -> first byte fully written to addr 0..7, second dropped, overrun=1, next accepted byte writes addr 8.
REQ-031 rst_n pulsed low after 40 bytes -> all outputs return to reset values immediately; next byte writes addr 0.
REQ-032 rx_rdy and img_ack both asserted in the same FULL cycle -> IDLE next cycle, pixel counter 0, overrun=1, no RAM write.
